// File: rtl/ctrl_pkg.sv
// Shared types and codes for the multi-cycle control unit: state encoding,
// opcodes, datapath select codes, the registered control word and decode helpers.
package ctrl_pkg;

    localparam int ALU_OP_BITS = 4;
    localparam int NPC_OP_BITS = 3;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    typedef enum logic [2:0] {
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXEC   = ST_EXEC,
        MEM    = ST_MEM,
        WB     = ST_WB,
        ERR    = ST_ERR
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam logic [2:0] NPC_PC4  = 3'b000;
    localparam logic [2:0] NPC_JAL  = 3'b010;
    localparam logic [2:0] NPC_JALR = 3'b011;
    localparam logic [2:0] NPC_BEQ  = 3'b100;
    localparam logic [2:0] NPC_BNE  = 3'b101;
    localparam logic [2:0] NPC_BLT  = 3'b110;
    localparam logic [2:0] NPC_BGE  = 3'b111;

    localparam logic [1:0] RIN_ALU = 2'b00;
    localparam logic [1:0] RIN_DM  = 2'b01;
    localparam logic [1:0] RIN_PC4 = 2'b10;
    localparam logic [1:0] RIN_IMM = 2'b11;

    typedef struct packed {
        logic                   alu_input;
        logic [ALU_OP_BITS-1:0] alu_op;
        logic                   dram_write;
        logic [1:0]             reg_input;
        logic                   reg_write;
        logic [NPC_OP_BITS-1:0] npc;
        logic                   mem_access;
    } ctrl_word_t;

    // funct = {funct7[5], funct3}; immediate forms only honour bit 3 for shifts
    function automatic logic [3:0] alu_op_imm(input logic [3:0] funct);
        case (funct[2:0])
            3'b001:  return ALU_SLL;
            3'b100:  return ALU_XOR;
            3'b101:  return funct[3] ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [3:0] alu_op_reg(input logic [3:0] funct);
        case (funct)
            4'b1000: return ALU_SUB;
            4'b0001: return ALU_SLL;
            4'b0100: return ALU_XOR;
            4'b0101: return ALU_SRL;
            4'b1101: return ALU_SRA;
            4'b0110: return ALU_OR;
            4'b0111: return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] npc_branch(input logic [2:0] funct3);
        case (funct3)
            3'b001:  return NPC_BNE;
            3'b100:  return NPC_BLT;
            3'b101:  return NPC_BGE;
            default: return NPC_BEQ;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_fsm_if.sv
// Instruction/data memory request-acknowledge handshake between the control
// unit (master) and the memories (slave).
interface ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;

    modport master (output imem_req, output dmem_req, input imem_ack, input dmem_ack);
    modport slave  (input imem_req, input dmem_req, output imem_ack, output dmem_ack);
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode/funct decoder producing the control word that the
// FSM registers in DECODE.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [3:0]  funct,
    output ctrl_word_t  cw,
    output logic        illegal
);

    always_comb begin
        cw      = '0;
        illegal = 1'b0;
        case (opcode)
            OP_IMM: begin
                cw.alu_op    = alu_op_imm(funct);
                cw.reg_input = RIN_ALU;
                cw.reg_write = 1'b1;
            end
            OP_REG: begin
                cw.alu_input = 1'b1;
                cw.alu_op    = alu_op_reg(funct);
                cw.reg_input = RIN_ALU;
                cw.reg_write = 1'b1;
            end
            OP_LOAD: begin
                cw.alu_op     = ALU_ADD;
                cw.reg_input  = RIN_DM;
                cw.reg_write  = 1'b1;
                cw.mem_access = 1'b1;
            end
            OP_STORE: begin
                cw.alu_op     = ALU_ADD;
                cw.dram_write = 1'b1;
                cw.mem_access = 1'b1;
            end
            OP_BRANCH: begin
                cw.alu_input = 1'b1;
                cw.alu_op    = ALU_SUB;
                cw.npc       = npc_branch(funct[2:0]);
            end
            OP_JAL: begin
                cw.reg_input = RIN_PC4;
                cw.reg_write = 1'b1;
                cw.npc       = NPC_JAL;
            end
            OP_JALR: begin
                cw.alu_op    = ALU_ADD;
                cw.reg_input = RIN_PC4;
                cw.reg_write = 1'b1;
                cw.npc       = NPC_JALR;
            end
            OP_LUI: begin
                cw.reg_input = RIN_IMM;
                cw.reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: sequences each instruction through fetch, decode,
// execute, memory and write-back with memory handshakes, timeout and retire count.
//
// state  | meaning
// FETCH  | imem_req held until imem_ack; ir_we on the ack cycle
// DECODE | control word captured; illegal pulse on unknown opcode
// EXEC   | select outputs valid; branch to MEM for loads/stores
// MEM    | dmem_req held until dmem_ack (store qualifier alongside)
// WB     | pc_we, optional RF write, instret increment
// ERR    | memory timeout; err high, everything else idle until rst
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W     = ALU_OP_BITS,
    parameter int NPCOP_W     = NPC_OP_BITS,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [3:0]         funct,
    ctrl_fsm_if.master         mem,
    output logic               ir_we,
    output logic               pc_we,
    output logic               ctrl_ALU_input,
    output logic [ALUOP_W-1:0] ctrl_ALU_output,
    output logic               ctrl_DRAM_write,
    output logic [1:0]         ctrl_Reg_input,
    output logic               ctrl_Reg_write,
    output logic [NPCOP_W-1:0] ctrl_NPC_output,
    output logic               illegal,
    output logic               err,
    output logic [CNT_W-1:0]   instret
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    ctrl_word_t         cw, cw_dec;
    logic               illegal_dec;
    logic [CNT_W-1:0]   instret_q;
    logic               waiting;
    logic               run;
    logic               in_sel;

    ctrl_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cw      (cw_dec),
        .illegal (illegal_dec)
    );

    assign waiting = (state == FETCH) || (state == MEM);

    // An ack on the terminal wait cycle is checked first, so it wins over timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (mem.imem_ack)              state_nxt = DECODE;
                else if (wait_cnt == WAIT_LAST) state_nxt = ERR;
            end
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = cw.mem_access ? MEM : WB;
            MEM: begin
                if (mem.dmem_ack)              state_nxt = WB;
                else if (wait_cnt == WAIT_LAST) state_nxt = ERR;
            end
            WB:     state_nxt = FETCH;
            ERR:    state_nxt = ERR;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            cw        <= '0;
            instret_q <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (waiting && state_nxt == state) ? wait_cnt + WAIT_W'(1) : '0;
            if (state == DECODE) cw <= cw_dec;
            if (state == WB) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Everything is forced low while rst is held, so acks seen then do nothing.
    assign run    = ~rst;
    assign in_sel = run && (state == EXEC || state == MEM || state == WB);

    assign mem.imem_req    = run && (state == FETCH);
    assign mem.dmem_req    = run && (state == MEM);
    assign ir_we           = mem.imem_req && mem.imem_ack;
    assign pc_we           = run && (state == WB);
    assign ctrl_Reg_write  = pc_we && cw.reg_write;
    assign ctrl_DRAM_write = mem.dmem_req && cw.dram_write;
    assign ctrl_ALU_input  = in_sel && cw.alu_input;
    assign ctrl_ALU_output = in_sel ? ALUOP_W'(cw.alu_op) : '0;
    assign ctrl_Reg_input  = in_sel ? cw.reg_input : 2'b00;
    assign ctrl_NPC_output = in_sel ? NPCOP_W'(cw.npc) : '0;
    assign illegal         = run && (state == DECODE) && illegal_dec;
    assign err             = run && (state == ERR);
    assign instret         = run ? instret_q : '0;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: a cycle-schedule model built from the
// instruction rules is compared against every DUT output on every negedge.
module tb_ctrl_fsm;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [3:0]  funct;
    logic        ir_we, pc_we, ctrl_ALU_input, ctrl_DRAM_write, ctrl_Reg_write, illegal, err;
    logic [3:0]  ctrl_ALU_output;
    logic [1:0]  ctrl_Reg_input;
    logic [2:0]  ctrl_NPC_output;
    logic [31:0] instret;

    ctrl_fsm_if mem ();

    ctrl_fsm #(.ALUOP_W(4), .NPCOP_W(3), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .opcode          (opcode),
        .funct           (funct),
        .mem             (mem),
        .ir_we           (ir_we),
        .pc_we           (pc_we),
        .ctrl_ALU_input  (ctrl_ALU_input),
        .ctrl_ALU_output (ctrl_ALU_output),
        .ctrl_DRAM_write (ctrl_DRAM_write),
        .ctrl_Reg_input  (ctrl_Reg_input),
        .ctrl_Reg_write  (ctrl_Reg_write),
        .ctrl_NPC_output (ctrl_NPC_output),
        .illegal         (illegal),
        .err             (err),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        imem_req;
        logic        dmem_req;
        logic        ir_we;
        logic        pc_we;
        logic        alu_in;
        logic [3:0]  alu_op;
        logic        dram_w;
        logic [1:0]  reg_in;
        logic        reg_w;
        logic [2:0]  npc;
        logic        illegal;
        logic        err;
        logic [31:0] instret;
    } obs_t;

    typedef struct packed {
        logic       alu_in;
        logic [3:0] alu_op;
        logic       dram_w;
        logic [1:0] reg_in;
        logic       reg_w;
        logic [2:0] npc;
        logic       illegal;
        logic       is_mem;
    } ref_t;

    // ALU op per funct3 (immediate) and per full funct (register); NPC per funct3
    localparam logic [3:0] IMM_TAB [8]  = '{0, 5, 0, 0, 4, 6, 3, 2};
    localparam logic [3:0] R_TAB   [16] = '{0, 5, 0, 0, 4, 6, 3, 2, 1, 0, 0, 0, 0, 7, 0, 0};
    localparam logic [2:0] BR_TAB  [8]  = '{4, 5, 4, 4, 6, 7, 4, 4};
    localparam logic [6:0] OPS     [10] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                            7'b1111111, 7'b0000000};

    obs_t        exp_o, act_o;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    int          dreq_cycles = 0;
    logic [31:0] exp_ret = '0;

    assign act_o = {mem.imem_req, mem.dmem_req, ir_we, pc_we, ctrl_ALU_input, ctrl_ALU_output,
                    ctrl_DRAM_write, ctrl_Reg_input, ctrl_Reg_write, ctrl_NPC_output,
                    illegal, err, instret};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL outputs t=%0t actual %h required %h", $time, act_o, exp_o);
            end
            if (mem.dmem_req === 1'b1) dreq_cycles++;
        end
    end

    function automatic ref_t ref_decode(input logic [6:0] op, input logic [3:0] fn);
        ref_t r;
        r = '0;
        case (op)
            7'b0010011: begin
                r.alu_op = (fn[2:0] == 3'b101 && fn[3]) ? 4'd7 : IMM_TAB[fn[2:0]];
                r.reg_w  = 1'b1;
            end
            7'b0110011: begin r.alu_in = 1'b1; r.alu_op = R_TAB[fn]; r.reg_w = 1'b1; end
            7'b0000011: begin r.reg_in = 2'd1; r.reg_w = 1'b1; r.is_mem = 1'b1; end
            7'b0100011: begin r.dram_w = 1'b1; r.is_mem = 1'b1; end
            7'b1100011: begin r.alu_in = 1'b1; r.alu_op = 4'd1; r.npc = BR_TAB[fn[2:0]]; end
            7'b1101111: begin r.reg_in = 2'd2; r.reg_w = 1'b1; r.npc = 3'd2; end
            7'b1100111: begin r.reg_in = 2'd2; r.reg_w = 1'b1; r.npc = 3'd3; end
            7'b0110111: begin r.reg_in = 2'd3; r.reg_w = 1'b1; end
            default:    r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    function automatic obs_t base_exp();
        obs_t o;
        o = '0;
        o.instret = exp_ret;
        return o;
    endfunction

    function automatic obs_t sel_exp(input ref_t r);
        obs_t o;
        o = base_exp();
        o.alu_in = r.alu_in;
        o.alu_op = r.alu_op;
        o.reg_in = r.reg_in;
        o.npc    = r.npc;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_acks();
        mem.imem_ack = 1'($urandom_range(0, 1));
        mem.dmem_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, expv);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        mem.imem_ack = 1'b1;
        mem.dmem_ack = 1'b1;
        opcode = 7'($urandom);
        funct  = 4'($urandom);
        exp_ret = '0;
        for (int i = 0; i < n; i++) begin
            exp_o = '0;
            step();
        end
        rst = 1'b0;
    endtask

    task automatic err_phase();
        for (int i = 0; i < 3; i++) begin
            exp_o = base_exp();
            exp_o.err = 1'b1;
            rand_acks();
            step();
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [3:0] fn, input int di, input int dd,
                             input int abort_at, output int ncyc, output bit timed_out,
                             output bit aborted);
        ref_t r;
        r = ref_decode(op, fn);
        ncyc = 0;
        timed_out = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (ncyc == abort_at) begin aborted = 1'b1; return; end
            exp_o = base_exp();
            exp_o.imem_req = 1'b1;
            exp_o.ir_we = (k == di);
            mem.imem_ack = (k == di);
            mem.dmem_ack = 1'($urandom_range(0, 1));
            opcode = 7'($urandom);
            funct  = 4'($urandom);
            step();
            ncyc++;
            if (k == di) break;
        end
        if (di >= TO) begin err_phase(); timed_out = 1'b1; return; end
        if (ncyc == abort_at) begin aborted = 1'b1; return; end
        exp_o = base_exp();
        exp_o.illegal = r.illegal;
        opcode = op;
        funct  = fn;
        rand_acks();
        step();
        ncyc++;
        if (ncyc == abort_at) begin aborted = 1'b1; return; end
        exp_o = sel_exp(r);
        rand_acks();
        step();
        ncyc++;
        if (r.is_mem) begin
            for (int k = 0; k < TO; k++) begin
                if (ncyc == abort_at) begin aborted = 1'b1; return; end
                exp_o = sel_exp(r);
                exp_o.dmem_req = 1'b1;
                exp_o.dram_w = r.dram_w;
                mem.dmem_ack = (k == dd);
                mem.imem_ack = 1'($urandom_range(0, 1));
                step();
                ncyc++;
                if (k == dd) break;
            end
            if (dd >= TO) begin err_phase(); timed_out = 1'b1; return; end
        end
        if (ncyc == abort_at) begin aborted = 1'b1; return; end
        exp_o = sel_exp(r);
        exp_o.pc_we = 1'b1;
        exp_o.reg_w = r.reg_w;
        rand_acks();
        step();
        ncyc++;
        exp_ret++;
    endtask

    initial begin
        int   n, di, dd, ab;
        bit   to, abt;
        ref_t rr;
        logic [6:0] op;

        rst = 1'b1;
        mem.imem_ack = 1'b1;
        mem.dmem_ack = 1'b0;
        opcode = '0;
        funct  = '0;
        exp_o  = '0;
        step();
        chk_en = 1'b1;
        do_reset(2);

        rr = ref_decode(7'b0110011, 4'b0000);
        check_lit("ref_add_alu_op", 32'(rr.alu_op), 32'd0);
        check_lit("ref_add_alu_in", 32'(rr.alu_in), 32'd1);
        rr = ref_decode(7'b1100011, 4'b0101);
        check_lit("ref_bge_alu_op", 32'(rr.alu_op), 32'd1);
        check_lit("ref_bge_npc", 32'(rr.npc), 32'd7);
        check_lit("ref_bge_reg_w", 32'(rr.reg_w), 32'd0);
        rr = ref_decode(7'b0010011, 4'b1101);
        check_lit("ref_srai_alu_op", 32'(rr.alu_op), 32'd7);
        rr = ref_decode(7'b1111111, 4'b0000);
        check_lit("ref_illegal", 32'(rr.illegal), 32'd1);
        check_lit("ref_illegal_npc", 32'(rr.npc), 32'd0);

        run_instr(7'b0110011, 4'b0000, 0, 0, -1, n, to, abt);
        check_lit("add_latency", 32'(n), 32'd4);
        check_lit("add_instret", instret, 32'd1);

        dreq_cycles = 0;
        run_instr(7'b0000011, 4'b0010, 0, 3, -1, n, to, abt);
        check_lit("lw_latency", 32'(n), 32'd8);
        check_lit("lw_dmem_req_cycles", 32'(dreq_cycles), 32'd4);

        run_instr(7'b1100011, 4'b0101, 1, 0, -1, n, to, abt);
        run_instr(7'b0010011, 4'b1101, 0, 0, -1, n, to, abt);
        run_instr(7'b1111111, 4'b0000, 0, 0, -1, n, to, abt);
        check_lit("illegal_latency", 32'(n), 32'd4);
        run_instr(7'b0100011, 4'b0010, 2, 1, -1, n, to, abt);

        run_instr(7'b0110011, 4'b0000, TO, 0, -1, n, to, abt);
        check_lit("timeout_req_cycles", 32'(n), 32'(TO));
        check_lit("timeout_err", 32'(err), 32'd1);
        check_lit("timeout_imem_req", 32'(mem.imem_req), 32'd0);
        do_reset(1);
        run_instr(7'b0110011, 4'b0000, TO - 1, 0, -1, n, to, abt);
        check_lit("late_ack_latency", 32'(n), 32'(TO + 3));
        check_lit("late_ack_no_err", 32'(err), 32'd0);
        run_instr(7'b0000011, 4'b0000, 0, TO - 1, -1, n, to, abt);
        check_lit("late_dmem_ack_no_err", 32'(err), 32'd0);

        run_instr(7'b0000011, 4'b0000, 0, 2, 4, n, to, abt);
        do_reset(1);
        check_lit("abort_dmem_req", 32'(mem.dmem_req), 32'd0);
        check_lit("abort_instret", instret, 32'd0);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 9)];
            di = ($urandom_range(0, 11) == 0) ? TO + int'($urandom_range(0, 1))
                                              : int'($urandom_range(0, TO - 1));
            dd = ($urandom_range(0, 11) == 0) ? TO + int'($urandom_range(0, 1))
                                              : int'($urandom_range(0, TO - 1));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_instr(op, 4'($urandom), di, dd, ab, n, to, abt);
            if (to || abt) do_reset(int'($urandom_range(1, 2)));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
